// File: rtl/ucaspian_synapse_if.sv
`default_nettype none
// ============================================================================
// Module      : ucaspian_syn_range_if / ucaspian_dend_if
// Description : Handshake channels for the synapse stage.
//               ucaspian_syn_range_if : inclusive synapse-index range, axon
//                                       side is master, synapse side slave.
//               ucaspian_dend_if      : (target, signed charge) events,
//                                       synapse side is master, neuron side
//                                       slave.
// Revision    : 1.0 - initial release
// ============================================================================

interface ucaspian_syn_range_if #(
   parameter int SYN_W = 12
);
   logic [SYN_W-1:0] syn_start;   // first index (inclusive)
   logic [SYN_W-1:0] syn_end;     // last index (inclusive)
   logic             syn_vld;
   logic             syn_rdy;

   modport master (output syn_start, output syn_end, output syn_vld, input  syn_rdy);
   modport slave  (input  syn_start, input  syn_end, input  syn_vld, output syn_rdy);
endinterface

interface ucaspian_dend_if #(
   parameter int NEUR_W = 8,
   parameter int WGT_W  = 8
);
   logic [NEUR_W-1:0] dend_addr;    // target neuron id
   logic [WGT_W-1:0]  dend_charge;  // signed weight
   logic              dend_vld;
   logic              dend_rdy;

   modport master (output dend_addr, output dend_charge, output dend_vld, input  dend_rdy);
   modport slave  (input  dend_addr, input  dend_charge, input  dend_vld, output dend_rdy);
endinterface

`default_nettype wire

// File: rtl/ucaspian_synapse.sv
`default_nettype none
// ============================================================================
// Module      : ucaspian_synapse
// Description : Walks an inclusive synapse-index range one index per cycle,
//               reads (weight, target) from the synapse RAM and emits
//               non-zero-weight events to the dendrite accumulator. Also
//               owns synapse-RAM configuration and whole-RAM clearing.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               i_enable          - run enable (pauses issue / acceptance)
//               i_clear_config    - level; zero the whole RAM
//               o_clear_done      - clear finished while i_clear_config held
//               i_config_*        - byte-wise RAM configuration
//               i_next_step       - time-step boundary pulse
//               o_step_done       - idle and drained
//               syn               - range channel (slave)
//               dend              - event channel (master)
// Revision    : 1.0 - initial release
// ============================================================================

module ucaspian_synapse #(
   parameter int SYN_W  = 12,
   parameter int NEUR_W = 8,   // must be <= 8 (loaded from one config byte)
   parameter int WGT_W  = 8    // must be <= 8 (loaded from one config byte)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_clear_config,
   output logic             o_clear_done,
   input  logic [SYN_W-1:0] i_config_addr,
   input  logic [7:0]       i_config_value,
   input  logic [1:0]       i_config_byte,
   input  logic             i_config_enable,
   input  logic             i_next_step,
   output logic             o_step_done,
   ucaspian_syn_range_if.slave syn,
   ucaspian_dend_if.master     dend
);

   localparam int               c_ENTRY_W = WGT_W + NEUR_W;
   localparam int               c_DEPTH   = 2 ** SYN_W;
   localparam logic [SYN_W-1:0] c_LAST    = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WALK  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   state_t               r_state;
   logic [c_ENTRY_W-1:0] r_ram [c_DEPTH];   // [hi] weight, [lo] target
   logic [SYN_W-1:0]     r_cur;
   logic [SYN_W-1:0]     r_end;
   logic [SYN_W-1:0]     r_clr_idx;
   logic [WGT_W-1:0]     r_wstage;
   logic                 r_rd_vld;          // read issued last cycle
   logic [c_ENTRY_W-1:0] r_rd_data;
   logic [c_ENTRY_W-1:0] r_fifo [2];
   logic                 r_wptr;
   logic                 r_rptr;
   logic [1:0]           r_cnt;
   logic                 r_clear_done;
   logic                 r_step_done;

   logic                 w_pop;
   logic                 w_push;
   logic [2:0]           w_occ;
   logic                 w_issue;
   logic                 w_clr_wr;
   logic                 w_cfg_wr;

   assign w_pop  = (r_cnt != 2'd0) & dend.dend_rdy;
   assign w_push = r_rd_vld & (r_rd_data[c_ENTRY_W-1 -: WGT_W] != '0);

   // Occupancy the FIFO will have once everything already requested lands;
   // issuing only below 2 guarantees the returning read always has a slot.
   assign w_occ   = {1'b0, r_cnt} + {2'b00, r_rd_vld} - {2'b00, w_pop};
   assign w_issue = (r_state == ST_WALK) & i_enable & ~i_clear_config & (w_occ < 3'd2);

   assign w_clr_wr = ~reset & (r_state == ST_CLEAR) & i_clear_config & ~r_clear_done;
   assign w_cfg_wr = ~reset & ~i_clear_config & i_config_enable & (i_config_byte == 2'd1);

   assign syn.syn_rdy     = (r_state == ST_IDLE) & i_enable & ~reset & ~i_clear_config;
   assign dend.dend_vld   = (r_cnt != 2'd0);
   assign dend.dend_addr  = r_fifo[r_rptr][NEUR_W-1:0];
   assign dend.dend_charge= r_fifo[r_rptr][c_ENTRY_W-1 -: WGT_W];
   assign o_clear_done    = r_clear_done;
   assign o_step_done     = r_step_done;

   // Write port: clearing has priority over configuration.
   always_ff @(posedge clk) begin
      if (w_clr_wr)
         r_ram[r_clr_idx] <= '0;
      else if (w_cfg_wr)
         r_ram[i_config_addr] <= {r_wstage, i_config_value[NEUR_W-1:0]};
   end

   // Read port: one-cycle registered read for the walk.
   always_ff @(posedge clk) begin
      if (w_issue)
         r_rd_data <= r_ram[r_cur];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cur        <= '0;
         r_end        <= '0;
         r_clr_idx    <= '0;
         r_wstage     <= '0;
         r_rd_vld     <= 1'b0;
         r_fifo[0]    <= '0;
         r_fifo[1]    <= '0;
         r_wptr       <= 1'b0;
         r_rptr       <= 1'b0;
         r_cnt        <= 2'd0;
         r_clear_done <= 1'b0;
         r_step_done  <= 1'b0;
      end else begin
         if (~i_clear_config & i_config_enable & (i_config_byte == 2'd0))
            r_wstage <= i_config_value[WGT_W-1:0];

         r_step_done <= (r_state == ST_IDLE) & ~r_rd_vld & (r_cnt == 2'd0)
                        & ~syn.syn_vld & ~i_next_step;

         if (i_clear_config) begin
            // Abort any walk and flush the output buffer.
            r_rd_vld <= 1'b0;
            r_cnt    <= 2'd0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            if (r_state != ST_CLEAR) begin
               r_state      <= ST_CLEAR;
               r_clr_idx    <= '0;
               r_clear_done <= 1'b0;
            end else if (w_clr_wr) begin
               r_clr_idx <= r_clr_idx + 1'b1;
               if (r_clr_idx == c_LAST)
                  r_clear_done <= 1'b1;
            end
         end else begin
            r_clear_done <= 1'b0;
            r_rd_vld     <= w_issue;

            if (w_push) begin
               r_fifo[r_wptr] <= r_rd_data;
               r_wptr         <= ~r_wptr;
            end
            if (w_pop)
               r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};

            case (r_state)
               ST_IDLE: begin
                  // A reversed range is consumed but produces nothing.
                  if (syn.syn_vld & syn.syn_rdy & (syn.syn_end >= syn.syn_start)) begin
                     r_cur   <= syn.syn_start;
                     r_end   <= syn.syn_end;
                     r_state <= ST_WALK;
                  end
               end
               ST_WALK: begin
                  if (w_issue) begin
                     r_cur <= r_cur + 1'b1;
                     if (r_cur == r_end)
                        r_state <= ST_IDLE;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/ucaspian_synapse.md
Name: ucaspian_synapse

Overview:
- Consumer end of the axon→synapse range interface.
- Accepts one inclusive synapse-index range per handshake and walks it one index per cycle.
- Reads each synapse entry (weight, target neuron) from a 4096-entry synapse RAM.
- Emits (target, signed charge) events to the dendrite/neuron accumulator over a valid/ready interface.
- Also owns synapse-RAM configuration and clearing.

Parameters:
SYN_W, 12, synapse index width (RAM depth 2^SYN_W)
NEUR_W, 8, target neuron id width
WGT_W, 8, signed weight width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  run enable; low pauses new reads and acceptance
clear_config  in  1  level; zero the whole synapse RAM
clear_done  out  1  registered; high while clear_config held and clear finished
config_addr  in  12  synapse index to configure
config_value  in  8  configuration byte
config_byte  in  2  0: stage weight, 1: stage target and write
config_enable  in  1  configuration strobe
next_step  in  1  time-step boundary pulse
step_done  out  1  registered; block idle and drained
syn_start  in  12  first synapse index (inclusive)
syn_end  in  12  last synapse index (inclusive)
syn_vld  in  1  range valid
syn_rdy  out  1  range ready
dend_addr  out  8  target neuron id
dend_charge  out  8  signed weight
dend_vld  out  1  event valid
dend_rdy  in  1  event ready

Behaviour:
- One clock (clk). Reset is synchronous and active-high.
- Reset values:
  - dend_vld, step_done, clear_done = 0.
  - dend_addr, dend_charge = 0.
  - FSM = IDLE.
  - Output buffer empty; in-flight read dropped.
- Synapse RAM: 16 bits per entry, [15:8] weight, [7:0] target. 1-cycle registered read. Simple dual-port: the CLEAR/config write port is separate from the walk read port.
- Configuration (only when not clear_config):
  - byte 0 latches config_value into the weight stage.
  - byte 1 writes {weight stage, config_value} at config_addr.
  - Other codes are ignored.
- FSM states: IDLE, WALK, CLEAR.
  - IDLE: syn_rdy = enable & ~reset & ~clear_config. On syn_vld&syn_rdy, latch start/end.
    - end ≥ start: cur = start, go to WALK.
    - end < start: range dropped, stay IDLE, no events.
  - WALK: a read of cur issues in any cycle where enable=1 and (buffer occupancy + in-flight − pop this cycle) < 2.
    - Each issue increments cur.
    - Issuing cur == end returns the FSM to IDLE next cycle.
    - The range is never wrapped past 4095.
  - CLEAR: entered from any state when clear_config=1. Takes priority over walk and config.
    - Flushes the buffer and aborts any walk.
    - Writes zero to indices 0..4095, one per cycle.
    - clear_done is registered high from the cycle after index 4095 is written, for as long as clear_config stays high.
    - Deasserting clear_config returns to IDLE and clears clear_done.
- Output buffer: 2-entry FIFO fed by read data one cycle after issue.
  - Entries with weight == 0 are discarded and never enter the FIFO.
  - dend_vld = FIFO non-empty; head drives dend_addr/dend_charge.
  - Pop on dend_vld&dend_rdy. Head is stable while stalled.
  - Strict index order.
- Throughput: 1 event/cycle with dend_rdy=1.
- Latency: first dend_vld is high 2 cycles after the accepting edge.
- syn_rdy stays low until the FSM has returned to IDLE. The buffer may still hold entries when the next range is accepted.
- step_done: registered. High when FSM=IDLE, no read in flight, FIFO empty and syn_vld=0. Forced low the cycle after next_step.
- next_step while WALK has no effect on the walk.
- enable low mid-walk: issue pauses and cur holds; FIFO continues to drain.
- Reset mid-walk or mid-clear: immediately returns to the reset values above. RAM contents are not altered by reset.

Test Plan:
- Basic walk: config idx10 = (w 0x05, t 3), idx11 = (w 0xFE, t 7); send range 10..11 with dend_rdy=1 → (3,+5) then (7,−2) on consecutive cycles. First dend_vld 2 cycles after accept; step_done rises after the drain.
- Backpressure: idx0..7 weights 1..8 to targets 0..7; range 0..7 with dend_rdy alternating 1/0 → exactly 8 events in order. No duplicates; data held while dend_rdy=0.
- Zero-weight suppression: range 20..23 with idx21 weight 0 → 3 events (idx20, 22, 23). syn_rdy returns high 4 issue cycles after accept.
- Boundaries:
  - Range 4095..4095 → one event, no wrap.
  - Range 9..5 → accepted, zero events, FSM stays IDLE.
- Clear: assert clear_config mid-walk → dend_vld drops next cycle. clear_done goes high after 4096 writes. Range 0..15 afterwards → no events.
- Reset: assert reset for 1 cycle during a 100-entry walk → dend_vld=0, syn_rdy returns high the cycle after reset deasserts. A new range 10..10 yields exactly one event.
